// File: rtl/twenty_bit_divider_ctrl_if.sv
// Start/done request bus between a single requester and the 20-bit divider.
// The requester drives the operands and start; the divider returns status and results.
interface twenty_bit_divider_ctrl_if #(
    parameter int WIDTH = 20
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/twenty_bit_divider_ctrl.sv
// Restoring 20-bit unsigned divider: one shared subtractor, one iteration per clock.
// Results and div_by_zero update only when DONE is entered and hold until the next one.
module twenty_bit_subtractor (
    input  logic [19:0] i0,
    input  logic [19:0] i1,
    output logic [19:0] diff,
    output logic        bout
);
    assign {bout, diff} = {1'b0, i0} - {1'b0, i1};
endmodule

module twenty_bit_divider_ctrl #(
    parameter int WIDTH = 20,
    parameter int ITER  = 20
) (
    input  logic                        clk,
    input  logic                        rst_n,
    twenty_bit_divider_ctrl_if.slave    bus
);
    localparam int CNT_W = $clog2(ITER + 1);

    if (WIDTH != 20 || ITER != WIDTH) begin : g_param_check
        $error("twenty_bit_divider_ctrl supports only WIDTH = ITER = 20");
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             state_q,     state_d;
    logic [CNT_W-1:0]   count_q,     count_d;
    logic [WIDTH-1:0]   q_q,         q_d;
    logic [WIDTH-1:0]   d_q,         d_d;
    logic [WIDTH-1:0]   r_q,         r_d;
    logic [WIDTH-1:0]   quotient_q,  quotient_d;
    logic [WIDTH-1:0]   remainder_q, remainder_d;
    logic               dbz_q,       dbz_d;
    logic               done_q,      done_d;

    logic [WIDTH-1:0]   partial;
    logic [WIDTH-1:0]   diff;
    logic               bout;
    logic               take;
    logic [WIDTH-1:0]   q_next;
    logic [WIDTH-1:0]   r_next;

    assign partial = {r_q[WIDTH-2:0], q_q[WIDTH-1]};

    twenty_bit_subtractor u_sub (
        .i0   (partial),
        .i1   (d_q),
        .diff (diff),
        .bout (bout)
    );

    // A set R[19] means the 21-bit partial remainder already exceeds any divisor,
    // so the wrapped low 20 bits of the difference are the correct new remainder.
    assign take   = r_q[WIDTH-1] | ~bout;
    assign r_next = take ? diff : partial;
    assign q_next = {q_q[WIDTH-2:0], take};

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        q_d         = q_q;
        d_d         = d_q;
        r_d         = r_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    q_d     = bus.dividend;
                    d_d     = bus.divisor;
                    r_d     = '0;
                    count_d = '0;
                    if (bus.divisor == '0) begin
                        state_d     = S_DONE;
                        done_d      = 1'b1;
                        quotient_d  = '1;
                        remainder_d = bus.dividend;
                        dbz_d       = 1'b1;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                q_d = q_next;
                r_d = r_next;
                if (count_q != CNT_W'(ITER)) begin
                    count_d = count_q + 1'b1;
                end
                if (count_q >= CNT_W'(ITER - 1)) begin
                    state_d     = S_DONE;
                    done_d      = 1'b1;
                    quotient_d  = q_next;
                    remainder_d = r_next;
                    dbz_d       = 1'b0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            q_q         <= '0;
            d_q         <= '0;
            r_q         <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            q_q         <= q_d;
            d_q         <= d_d;
            r_q         <= r_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            done_q      <= done_d;
        end
    end

    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done        = done_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_twenty_bit_divider_ctrl.sv
// Bench for twenty_bit_divider_ctrl: directed table, busy/reset corner sequences,
// and random operands checked against plain integer division.
module tb_twenty_bit_divider_ctrl;
    logic clk;
    logic rst_n;

    twenty_bit_divider_ctrl_if #(.WIDTH(20)) bus ();

    twenty_bit_divider_ctrl #(.WIDTH(20), .ITER(20)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [19:0] a;
        logic [19:0] b;
        logic [19:0] q;
        logic [19:0] r;
        logic        dbz;
    } vec_t;

    int checks = 0;
    int errors = 0;

    logic [19:0] prev_q;
    logic [19:0] prev_r;
    logic        prev_dbz;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issues one division and follows it until busy drops, with an optional
    // extra start pulse injected while the divider is running.
    task automatic run_div(input logic [19:0] a, input logic [19:0] b,
                           input logic [19:0] eq, input logic [19:0] er,
                           input logic edbz, input bit inject);
        int done_k, done_n, busy_n, exp_k, exp_busy;
        bit fin;
        exp_k    = (b == 0) ? 0 : 20;
        exp_busy = (b == 0) ? 1 : 21;
        @(negedge clk);
        bus.dividend = a;
        bus.divisor  = b;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        done_k = -1;
        done_n = 0;
        busy_n = 0;
        fin    = 1'b0;
        for (int k = 0; k < 60 && !fin; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            if (inject && k == 4) begin
                bus.start    = 1'b1;
                bus.dividend = 20'd1;
                bus.divisor  = 20'd1;
            end
            if (inject && k == 5) bus.start = 1'b0;
            if (bus.busy) busy_n++;
            if (bus.done) begin
                done_n++;
                if (done_k < 0) done_k = k;
            end
            if (k == 10 && b != 0) begin
                check("hold_quotient_mid_run", bus.quotient, prev_q);
                check("hold_remainder_mid_run", bus.remainder, prev_r);
                check("hold_dbz_mid_run", bus.div_by_zero, prev_dbz);
            end
            if (!bus.busy) fin = 1'b1;
        end
        check("no_timeout", fin, 1);
        check("done_latency", done_k, exp_k);
        check("done_pulses", done_n, 1);
        check("busy_cycles", busy_n, exp_busy);
        check("done_low_in_idle", bus.done, 0);
        check("quotient", bus.quotient, eq);
        check("remainder", bus.remainder, er);
        check("div_by_zero", bus.div_by_zero, edbz);
        prev_q   = eq;
        prev_r   = er;
        prev_dbz = edbz;
    endtask

    initial begin
        vec_t vt[$];
        logic [19:0] ra, rb;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        prev_q   = '0;
        prev_r   = '0;
        prev_dbz = 1'b0;

        vt.push_back('{20'd72,     20'd27,     20'd2,      20'd18,     1'b0});
        vt.push_back('{20'd0,      20'd1,      20'd0,      20'd0,      1'b0});
        vt.push_back('{20'd110,    20'd110,    20'd1,      20'd0,      1'b0});
        vt.push_back('{20'hFFFFF,  20'h80000,  20'd1,      20'h7FFFF,  1'b0});
        vt.push_back('{20'hFFFFF,  20'd1,      20'hFFFFF,  20'd0,      1'b0});
        vt.push_back('{20'd5,      20'd0,      20'hFFFFF,  20'd5,      1'b1});
        vt.push_back('{20'd9,      20'd3,      20'd3,      20'd0,      1'b0});
        vt.push_back('{20'd3,      20'hFFFFF,  20'd0,      20'd3,      1'b0});

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check("reset_quotient", bus.quotient, 0);
        check("reset_remainder", bus.remainder, 0);
        check("reset_dbz", bus.div_by_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vt[i]) run_div(vt[i].a, vt[i].b, vt[i].q, vt[i].r, vt[i].dbz, 1'b0);

        // Start while running must not disturb the in-flight 100 / 7.
        run_div(20'd100, 20'd7, 20'd14, 20'd2, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("ignored_start_no_restart", bus.busy, 0);
        check("ignored_start_no_done", bus.done, 0);

        // Reset in the middle of RUN aborts with no done pulse.
        @(negedge clk);
        bus.dividend = 20'd100;
        bus.divisor  = 20'd7;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_quotient", bus.quotient, 0);
        check("abort_remainder", bus.remainder, 0);
        check("abort_dbz", bus.div_by_zero, 0);
        repeat (2) begin
            @(posedge clk);
            #1;
            check("abort_no_done", bus.done, 0);
        end
        @(negedge clk);
        rst_n    = 1'b1;
        prev_q   = '0;
        prev_r   = '0;
        prev_dbz = 1'b0;
        run_div(20'd100, 20'd7, 20'd14, 20'd2, 1'b0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            ra = 20'($urandom_range(0, 20'hFFFFF));
            case ($urandom_range(0, 4))
                0:       rb = 20'($urandom_range(1, 15));
                1:       rb = 20'($urandom_range(0, 20'hFFFFF));
                2:       rb = 20'd0;
                3:       rb = 20'($urandom_range(20'h7FFFF, 20'hFFFFF));
                default: rb = 20'($urandom_range(1, 1023));
            endcase
            if (rb == 0) run_div(ra, rb, 20'hFFFFF, ra, 1'b1, 1'b0);
            else         run_div(ra, rb, ra / rb, ra % rb, 1'b0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
